// File: rtl/switch_allocator.sv
// Purpose: five-port crossbar switch allocator, one round-robin arbiter per output with wormhole locking.
// Latency: zero; grant and selects are combinational from requests plus registered lock/owner/ptr state.
// Backpressure: out_ready low on an output grants nobody there and holds all of that output's state.
module switch_allocator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  req_valid,
    input  logic [14:0] req_dst,
    input  logic [4:0]  req_tail,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant,
    output logic [2:0]  S_E,
    output logic [2:0]  S_W,
    output logic [2:0]  S_N,
    output logic [2:0]  S_S,
    output logic [2:0]  S_Ejec
);

    localparam int         NP       = 5;
    localparam logic [2:0] SEL_IDLE = 3'd7;

    // Per-output arbiter state: wormhole reservation plus round-robin pointer.
    typedef struct packed {
        logic       lock;
        logic [2:0] owner;
        logic [2:0] ptr;
    } arb_t;

    arb_t       arb_q   [NP];
    arb_t       arb_d   [NP];
    logic [4:0] cand    [NP];   // cand[o][i]: input i is a legal requester for output o
    logic [4:0] win_vld;
    logic [2:0] win     [NP];
    logic [4:0] grant_raw;

    // (p + k) mod 5 for p in 0..4 and k in 0..4.
    function automatic logic [2:0] rr_idx(input logic [2:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NP) begin
            s = s - NP;
        end
        return 3'(s);
    endfunction

    // Candidate matrix: valid, addressed to o, and not a U-turn. dst 5..7 matches nothing.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NP; i++) begin
                cand[o][i] = req_valid[i] && (req_dst[3*i +: 3] == 3'(o)) && (o != i);
            end
        end
    end

    // Per-output arbitration: locked outputs serve only their owner, free ones search from ptr.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            win_vld[o] = 1'b0;
            win[o]     = 3'd0;
            if (out_ready[o]) begin
                if (arb_q[o].lock) begin
                    if (cand[o][arb_q[o].owner]) begin
                        win_vld[o] = 1'b1;
                        win[o]     = arb_q[o].owner;
                    end
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        if (!win_vld[o] && cand[o][rr_idx(arb_q[o].ptr, k)]) begin
                            win_vld[o] = 1'b1;
                            win[o]     = rr_idx(arb_q[o].ptr, k);
                        end
                    end
                end
            end
        end
    end

    // Fold per-output winners back into per-input grants; each input names one output.
    always_comb begin
        grant_raw = '0;
        for (int o = 0; o < NP; o++) begin
            if (win_vld[o]) begin
                grant_raw[win[o]] = 1'b1;
            end
        end
    end

    // Drive outputs; reset forces everything idle regardless of requests.
    always_comb begin
        grant  = rst_n ? grant_raw : 5'b0;
        S_E    = (rst_n && win_vld[0]) ? win[0] : SEL_IDLE;
        S_W    = (rst_n && win_vld[1]) ? win[1] : SEL_IDLE;
        S_N    = (rst_n && win_vld[2]) ? win[2] : SEL_IDLE;
        S_S    = (rst_n && win_vld[3]) ? win[3] : SEL_IDLE;
        S_Ejec = (rst_n && win_vld[4]) ? win[4] : SEL_IDLE;
    end

    // Next state: heads/bodies reserve the output, tails release it and advance priority past the winner.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            arb_d[o] = arb_q[o];
            if (win_vld[o]) begin
                if (req_tail[win[o]]) begin
                    arb_d[o].lock = 1'b0;
                    arb_d[o].ptr  = rr_idx(win[o], 1);
                end else begin
                    arb_d[o].lock  = 1'b1;
                    arb_d[o].owner = win[o];
                end
            end
        end
    end

    // State register with synchronous active-low reset; reset drops every lock.
    always_ff @(posedge clk) begin
        for (int o = 0; o < NP; o++) begin
            if (!rst_n) begin
                arb_q[o] <= '0;
            end else begin
                arb_q[o] <= arb_d[o];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Purpose: self-checking bench for switch_allocator; directed scenarios then randomized traffic.
// Latency: outputs sampled mid-cycle, reference state advanced once per rising edge.
// Backpressure: out_ready is driven directly by the stimulus, both directed and random.
module tb_switch_allocator;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [14:0] req_dst;
    logic [4:0]  req_tail;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [2:0]  S_E, S_W, S_N, S_S, S_Ejec;
    logic [2:0]  sel_obs [5];

    int errors = 0;
    int checks = 0;

    // Reference model: which input holds each output (-1 = free) and who has priority next.
    int         m_owner [5];
    int         m_ptr   [5];
    int         exp_win [5];
    logic [4:0] exp_grant;

    switch_allocator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .S_E       (S_E),
        .S_W       (S_W),
        .S_N       (S_N),
        .S_S       (S_S),
        .S_Ejec    (S_Ejec)
    );

    assign sel_obs[0] = S_E;
    assign sel_obs[1] = S_W;
    assign sel_obs[2] = S_N;
    assign sel_obs[3] = S_S;
    assign sel_obs[4] = S_Ejec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_dst(input int i, input int d);
        req_dst[3*i +: 3] = 3'(d);
    endtask

    function automatic bit m_cand(input int i, input int o);
        return req_valid[i] && (int'(req_dst[3*i +: 3]) == o) && (i != o);
    endfunction

    task automatic m_reset();
        for (int o = 0; o < 5; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
    endtask

    // Who should cross this cycle, straight from the arbitration rules.
    task automatic model_eval();
        exp_grant = '0;
        for (int o = 0; o < 5; o++) begin
            exp_win[o] = -1;
            if (rst_n && out_ready[o]) begin
                if (m_owner[o] >= 0) begin
                    if (m_cand(m_owner[o], o)) exp_win[o] = m_owner[o];
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        if (exp_win[o] < 0 && m_cand((m_ptr[o] + k) % 5, o))
                            exp_win[o] = (m_ptr[o] + k) % 5;
                    end
                end
            end
            if (exp_win[o] >= 0) exp_grant[exp_win[o]] = 1'b1;
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_reset();
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (exp_win[o] >= 0) begin
                    if (req_tail[exp_win[o]]) begin
                        m_owner[o] = -1;
                        m_ptr[o]   = (exp_win[o] + 1) % 5;
                    end else begin
                        m_owner[o] = exp_win[o];
                    end
                end
            end
        end
    endtask

    // Mid-cycle sample of all outputs against the reference model.
    task automatic eval(input string tag);
        #3;
        model_eval();
        chk($sformatf("%s.grant", tag), grant, exp_grant);
        for (int o = 0; o < 5; o++) begin
            chk($sformatf("%s.sel%0d", tag, o), 5'(sel_obs[o]),
                (exp_win[o] < 0) ? 5'd7 : 5'(exp_win[o]));
        end
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [6] = '{0, 1, 3, 4, 0, 1};

    initial begin
        rst_n = 1'b0; req_valid = '0; req_dst = '0; req_tail = '0; out_ready = '1;
        m_reset();
        @(posedge clk);
        #1;

        // Reset holds everything idle even with every input requesting.
        req_valid = 5'b11111; req_tail = 5'b11111;
        set_dst(0, 1); set_dst(1, 0); set_dst(2, 3); set_dst(3, 2); set_dst(4, 0);
        eval("rst");
        chk("rst_grant", grant, 5'b0);
        chk("rst_S_E", 5'(S_E), 5'd7);
        chk("rst_S_N", 5'(S_N), 5'd7);
        chk("rst_S_Ejec", 5'(S_Ejec), 5'd7);
        advance();

        // Release: E and W both ask for N; E first, then W.
        rst_n = 1'b1; req_valid = 5'b00011; set_dst(0, 2); set_dst(1, 2);
        eval("rel0");
        chk("rel0_grant", grant, 5'b00001);
        chk("rel0_S_N", 5'(S_N), 5'd0);
        advance();
        req_valid = 5'b00010;
        eval("rel1");
        chk("rel1_grant", grant, 5'b00010);
        chk("rel1_S_N", 5'(S_N), 5'd1);
        advance();

        // Round-robin wrap on N from a fresh pointer.
        rst_n = 1'b0; req_valid = '0;
        eval("rr_rst");
        advance();
        rst_n = 1'b1; req_valid = 5'b11011; req_tail = '1;
        set_dst(0, 2); set_dst(1, 2); set_dst(3, 2); set_dst(4, 2);
        for (int k = 0; k < 6; k++) begin
            eval("rr");
            chk($sformatf("rr%0d_S_N", k), 5'(S_N), 5'(rr_seq[k]));
            chk($sformatf("rr%0d_grant", k), grant, 5'(1 << rr_seq[k]));
            advance();
        end

        // Wormhole: W sends 4 flits to E, S arrives in cycle 2 and must wait.
        set_dst(1, 0); set_dst(3, 0);
        for (int c = 1; c <= 5; c++) begin
            req_valid = (c == 1) ? 5'b00010 : (c <= 4) ? 5'b01010 : 5'b01000;
            req_tail  = (c == 4) ? 5'b01010 : 5'b01000;
            eval("worm");
            if (c <= 4) begin
                chk($sformatf("worm%0d_S_E", c), 5'(S_E), 5'd1);
                chk($sformatf("worm%0d_g3", c), 5'(grant[3]), 5'd0);
            end else begin
                chk("worm5_S_E", 5'(S_E), 5'd3);
                chk("worm5_grant", grant, 5'b01000);
            end
            advance();
        end

        // Backpressure on Eject.
        req_valid = 5'b00100; req_tail = '1; set_dst(2, 4); out_ready = 5'b01111;
        for (int c = 0; c < 3; c++) begin
            eval("bp");
            chk($sformatf("bp%0d_grant", c), grant, 5'b0);
            chk($sformatf("bp%0d_S_Ejec", c), 5'(S_Ejec), 5'd7);
            advance();
        end
        out_ready = '1;
        eval("bp_go");
        chk("bp_go_grant", grant, 5'b00100);
        chk("bp_go_S_Ejec", 5'(S_Ejec), 5'd2);
        advance();

        // Illegal U-turns and out-of-range dst stall; N->S still goes.
        req_valid = 5'b10111; req_tail = '1;
        set_dst(0, 0); set_dst(1, 6); set_dst(2, 3); set_dst(4, 4);
        eval("ill");
        chk("ill_grant", grant, 5'b00100);
        chk("ill_S_S", 5'(S_S), 5'd2);
        chk("ill_S_E", 5'(S_E), 5'd7);
        chk("ill_S_W", 5'(S_W), 5'd7);
        chk("ill_S_Ejec", 5'(S_Ejec), 5'd7);
        advance();

        // Reset mid-packet drops W's lock on E.
        req_valid = 5'b00010; req_tail = '0; set_dst(1, 0);
        eval("mid_head");
        chk("mid_head_S_E", 5'(S_E), 5'd1);
        advance();
        rst_n = 1'b0;
        eval("mid_rst");
        chk("mid_rst_grant", grant, 5'b0);
        advance();
        rst_n = 1'b1; req_valid = 5'b01000; req_tail = 5'b01000; set_dst(3, 0);
        eval("mid_after");
        chk("mid_after_S_E", 5'(S_E), 5'd3);
        chk("mid_after_grant", grant, 5'b01000);
        advance();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                set_dst(i, ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4));
                req_tail[i]  = ($urandom_range(0, 2) == 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            eval("rand");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
